mult: RTL and testbench
=======================

# mult

Iterative signed 32×32 multiplier using radix-2 Booth recoding. It is the companion of the divider in the MultDiv unit and writes the same HI/LO entrance buses. The control unit holds `multControl` high for the whole operation. After 34 clock edges the block drives the 64-bit two's-complement product onto `hi_entrance` (upper word) and `lo_entrance` (lower word).

## Interface
- `WIDTH`, default 32: operand width. The product is 2·`WIDTH` bits. Only 32 is verified.
- `clock` input 1: sole clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. 0 clears everything immediately.
- `regA_out` input 32: multiplicand M, signed.
- `regB_out` input 32: multiplier Q, signed.
- `multControl` input 1: operation request. Held high by the control unit for the whole operation.
- `hi_entrance` output 32: product bits [63:32]. Registered.
- `lo_entrance` output 32: product bits [31:0]. Registered.
- `multDone` output 1: one-cycle pulse on the cycle the product is written.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE, `multControl`=1 (LOAD edge):**
  - Latch M (sign-extended to 33 bits) and Q.
  - Clear accumulator A (33 bits) and Q₋₁.
  - Set count to 32. Go to RUN.
- **RUN, per edge (Booth step):**
  - {Q[0],Q₋₁}=01: A←A+M. 10: A←A−M. 00 or 11: A unchanged.
  - Arithmetic right shift of the 66-bit {A,Q,Q₋₁}, replicating A[32].
  - Decrement count.
- **RUN, count reaches 0:** go to DONE.
- **DONE entry edge:**
  - hi_entrance←A[31:0], lo_entrance←Q. multDone=1 for exactly this cycle.
  - Stay in DONE while `multControl`=1; no restart. Go to IDLE when `multControl`=0.
- **Arithmetic:** the 33-bit accumulator makes M=0x80000000 exact. The full 64-bit product is always exact; no overflow flag.
- **Abort:** `multControl` falls in RUN → next edge goes to IDLE. hi/lo are not written, keep their previous values, and multDone stays 0.
- **Operand changes:** regA_out/regB_out changes after the LOAD edge are ignored.
- **Reset:** asserting `reset` in any state forces:
  - state=IDLE; A, Q, Q₋₁, M, count=0;
  - hi_entrance=0, lo_entrance=0, multDone=0.
  - Release has no effect until the next edge with `multControl`=1 in IDLE.
- `multControl`=1 in the same cycle reset releases: the first edge after release is the LOAD edge.

## Timing
- Edge 1: LOAD. Edges 2–33: 32 Booth steps. Edge 34: hi/lo valid and multDone=1.
- Latency is fixed at 34 edges, independent of the operand values.
- hi/lo hold their value until the next completed operation or reset.
- A back-to-back operation needs at least one cycle of `multControl`=0 (DONE→IDLE). The minimum issue interval is 35 cycles.

## Structure
- Package `mult_pkg`:
  - state enum {IDLE, RUN, DONE};
  - constant MULT_STEPS=32;
  - constant ACC_W=WIDTH+1.
- Sub-module `booth_step`, purely combinational:
  - inputs {A,Q,Q₋₁} and M;
  - output the next {A,Q,Q₋₁} after one add/sub and shift.
- The top level holds the FSM, the counter and the output registers.

## Test plan
- 3×5 held 34 cycles → hi=0x00000000, lo=0x0000000F. multDone high only on edge 34.
- −3 (0xFFFFFFFD) × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also (−7)×(−6) → hi=0, lo=0x0000002A.
- Corner operands:
  - 0x80000000×0x80000000 → hi=0x40000000, lo=0x00000000.
  - 0x7FFFFFFF×0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001.
  - 0x80000000×1 → hi=0xFFFFFFFF, lo=0x80000000.
- Complete 2×2 (lo=4), then drop `multControl` at edge 10 of a 9×9 run → hi/lo stay 0/4 and multDone never pulses. Then keep `multControl` high 50 cycles after a done → exactly one multDone pulse.
- Assert `reset` low asynchronously mid-RUN, between edges, after a prior result of 0/15 → hi/lo/multDone go to 0 before the next edge. After release, a new 4×4 gives lo=16 at 34 edges.
- Randomised signed pairs against a 64-bit reference model. Operands are changed after LOAD → the result still matches the latched operands.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and constants for the Booth multiplier slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_STEPS = 32;
    localparam int ACC_W      = MULT_WIDTH + 1;
    localparam int CNT_W      = $clog2(MULT_STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_booth_step.sv
`default_nettype none
// ============================================================================
// Module      : booth_step
// Description : One radix-2 Booth iteration: add/sub M, then arithmetic
//               right shift of {A,Q,Q-1}. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_qm1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_q,
    output logic             o_qm1
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = i_acc;
        case ({i_q[0], i_qm1})
            2'b01:   w_sum = i_acc + i_m;
            2'b10:   w_sum = i_acc - i_m;
            default: w_sum = i_acc;
        endcase
    end

    assign o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_qm1 = i_q[0];

endmodule : booth_step
`default_nettype wire

// File: rtl/mult.sv
`default_nettype none
// ============================================================================
// Module      : mult
// Description : Iterative signed WIDTHxWIDTH Booth multiplier, fixed 34-edge
//               latency, writing the HI/LO entrance buses.
// Revision    : 1.0 - initial release
// ============================================================================
module mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] regA_out,
    input  logic [WIDTH-1:0] regB_out,
    input  logic             multControl,
    output logic [WIDTH-1:0] hi_entrance,
    output logic [WIDTH-1:0] lo_entrance,
    output logic             multDone
);

    localparam logic [CNT_W-1:0] c_STEPS = CNT_W'(MULT_STEPS);

    mult_state_e      r_state;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH:0]   r_m;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic [WIDTH:0]   w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_qm1_nxt;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_qm1 (r_qm1),
        .i_m   (r_m),
        .o_acc (w_acc_nxt),
        .o_q   (w_q_nxt),
        .o_qm1 (w_qm1_nxt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (multControl) begin
                        r_m     <= {regA_out[WIDTH-1], regA_out};
                        r_q     <= regB_out;
                        r_acc   <= '0;
                        r_qm1   <= 1'b0;
                        r_cnt   <= c_STEPS;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!multControl) begin
                        r_state <= IDLE;
                    end else if (r_cnt == '0) begin
                        // {A[WIDTH-1:0],Q} is the full product; A[WIDTH] is only a guard bit
                        r_hi    <= r_acc[WIDTH-1:0];
                        r_lo    <= r_q;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_q   <= w_q_nxt;
                        r_qm1 <= w_qm1_nxt;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (!multControl) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hi_entrance = r_hi;
    assign lo_entrance = r_lo;
    assign multDone    = r_done;

endmodule : mult
`default_nettype wire

// File: tb/tb_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult
// Description : Self-checking bench for the Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] regA_out;
    logic [31:0] regB_out;
    logic        multControl;
    logic [31:0] hi_entrance;
    logic [31:0] lo_entrance;
    logic        multDone;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[7];

    mult #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .regA_out    (regA_out),
        .regB_out    (regB_out),
        .multControl (multControl),
        .hi_entrance (hi_entrance),
        .lo_entrance (lo_entrance),
        .multDone    (multDone)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts edges from LOAD until multDone, then compares against the scoreboard
    task automatic wait_result(input string name, input bit scramble);
        int          edges;
        logic [63:0] exp;
        edges = 0;
        while (edges < 40) begin
            @(posedge clock);
            edges++;
            #1;
            if (scramble && edges == 1) begin
                regA_out = $urandom;
                regB_out = $urandom;
            end
            if (multDone) break;
        end
        chk({name, "_latency"}, 64'(edges), 64'd34);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard: got empty queue expected entry", name);
        end else begin
            exp = exp_q.pop_front();
            chk({name, "_product"}, {hi_entrance, lo_entrance}, exp);
        end
    endtask

    task automatic finish_op(input string name);
        @(negedge clock);
        multControl = 1'b0;
        @(posedge clock);
        #1;
        chk({name, "_done_pulse_end"}, 64'(multDone), 64'd0);
    endtask

    task automatic do_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input bit scramble);
        @(negedge clock);
        regA_out    = a;
        regB_out    = b;
        multControl = 1'b1;
        exp_q.push_back(exp);
        wait_result(name, scramble);
        finish_op(name);
    endtask

    initial begin
        int          pulses;
        logic [31:0] ra, rb;
        logic [63:0] rexp;

        vecs[0] = '{32'd3,         32'd5,         32'h00000000, 32'h0000000F};
        vecs[1] = '{32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{32'hFFFFFFF9,  32'hFFFFFFFA,  32'h00000000, 32'h0000002A};
        vecs[3] = '{32'h80000000,  32'h80000000,  32'h40000000, 32'h00000000};
        vecs[4] = '{32'h7FFFFFFF,  32'h7FFFFFFF,  32'h3FFFFFFF, 32'h00000001};
        vecs[5] = '{32'h80000000,  32'd1,         32'hFFFFFFFF, 32'h80000000};
        vecs[6] = '{32'd2,         32'd2,         32'h00000000, 32'h00000004};

        reset       = 1'b0;
        regA_out    = '0;
        regB_out    = '0;
        multControl = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", {hi_entrance, lo_entrance, 31'd0, multDone}, 96'd0);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i])
            do_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, 1'b0);

        // Abort a 9x9 run: control low before edge 10
        @(negedge clock);
        regA_out    = 32'd9;
        regB_out    = 32'd9;
        multControl = 1'b1;
        repeat (9) @(posedge clock);
        @(negedge clock);
        multControl = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (multDone) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        chk("abort_hold", {hi_entrance, lo_entrance}, 64'h00000000_00000004);

        // Control held long after completion yields a single pulse
        @(negedge clock);
        regA_out    = 32'd6;
        regB_out    = 32'd7;
        multControl = 1'b1;
        exp_q.push_back(64'd42);
        pulses = 0;
        repeat (50) begin
            @(posedge clock);
            #1;
            if (multDone) pulses++;
        end
        chk("hold_one_pulse", 64'(pulses), 64'd1);
        rexp = exp_q.pop_front();
        chk("hold_product", {hi_entrance, lo_entrance}, rexp);
        finish_op("hold");

        // Asynchronous reset mid-run after a 0/15 result
        do_mult("pre_reset", 32'd3, 32'd5, 64'd15, 1'b0);
        @(negedge clock);
        regA_out    = 32'd11;
        regB_out    = 32'd13;
        multControl = 1'b1;
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", {hi_entrance, lo_entrance, 31'd0, multDone}, 96'd0);
        regA_out = 32'd4;
        regB_out = 32'd4;
        @(negedge clock);
        reset = 1'b1;
        exp_q.push_back(64'd16);
        wait_result("post_reset", 1'b0);
        finish_op("post_reset");

        for (int i = 0; i < 20; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            if (i % 5 == 0) ra = 32'h80000000;
            rexp = 64'($signed(ra)) * 64'($signed(rb));
            do_mult($sformatf("rand%0d", i), ra, rb, rexp, i[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mult
`default_nettype wire
